// File: rtl/aes_axis_blk_packer_pkg.sv
// Shared widths, command bit indices, parser state encoding and the kernel-to-core
// byte swap used by the AES stream input path.
package aes_axis_blk_packer_pkg;

  localparam int BYTE_S = 8;
  localparam int WORD_S = 32;
  localparam int BLK_S  = 4 * WORD_S;

  localparam int CMD_ENC = 0;
  localparam int CMD_KEY = 1;

  typedef enum logic [1:0] {
    S_CMD   = 2'd0,
    S_KEY   = 2'd1,
    S_DATA  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  function automatic logic [31:0] swap_bytes32(input logic [31:0] w);
    return {w[0 +: BYTE_S], w[BYTE_S +: BYTE_S], w[2*BYTE_S +: BYTE_S], w[3*BYTE_S +: BYTE_S]};
  endfunction

endpackage

// File: rtl/aes_axis_blk_packer_outreg.sv
// Single-entry valid/ready holding register. The caller only loads it when it is
// empty or being drained in the same cycle.
module aes_blk_outreg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/aes_axis_blk_packer.sv
// Parses kernel AXI-stream packets (command, optional key, data blocks) into
// byte-order-corrected 128-bit blocks for the AES core.
//
// state   | meaning
// S_CMD   | waiting for the packet command word
// S_KEY   | collecting the 4 key words
// S_DATA  | collecting data blocks until tlast
// S_FLUSH | reserved, recovers to S_CMD
module aes_axis_blk_packer
  import aes_axis_blk_packer_pkg::*;
#(
  parameter int WORD_S = aes_axis_blk_packer_pkg::WORD_S,
  parameter int BLK_S  = aes_axis_blk_packer_pkg::BLK_S
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_S-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [0:BLK_S-1]  blk_data,
  output logic [WORD_S-1:0] blk_cmd,
  output logic              blk_is_key,
  output logic              blk_last,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              err_frame
);

  state_t                   r_state;
  logic [1:0]               r_wcnt;
  logic [0:BLK_S-WORD_S-1]  r_asm;
  logic [WORD_S-1:0]        r_cmd;
  logic                     r_err;

  logic [WORD_S-1:0]        w_word;
  logic                     w_collect;
  logic                     w_hold;
  logic                     w_tready;
  logic                     w_accept;
  logic                     w_load;
  logic                     w_blk_valid;
  logic [BLK_S+1:0]         w_out;

  assign w_word    = swap_bytes32(s_axis_tdata);
  assign w_collect = (r_state == S_KEY) || (r_state == S_DATA);
  assign w_hold    = w_blk_valid && !blk_ready;
  // Stall only where accepting would overwrite a pending block or its command.
  assign w_tready  = !reset && !(w_hold && ((w_collect && r_wcnt == 2'd3) || r_state == S_CMD));
  assign w_accept  = s_axis_tvalid && w_tready;
  assign w_load    = w_accept && w_collect && (r_wcnt == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_CMD;
      r_wcnt  <= 2'd0;
      r_asm   <= '0;
      r_cmd   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_CMD: if (w_accept) begin
          if (s_axis_tlast) begin
            r_err <= 1'b1;
          end else begin
            r_cmd   <= w_word;
            r_state <= w_word[CMD_KEY] ? S_KEY : S_DATA;
          end
        end
        S_KEY, S_DATA: if (w_accept) begin
          if (s_axis_tlast && r_wcnt != 2'd3) begin
            r_err   <= 1'b1;
            r_wcnt  <= 2'd0;
            r_state <= S_CMD;
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
            if (r_wcnt != 2'd3) r_asm[r_wcnt*WORD_S +: WORD_S] <= w_word;
            else r_state <= s_axis_tlast ? S_CMD : S_DATA;
          end
        end
        default: begin
          r_state <= S_CMD;
          r_wcnt  <= 2'd0;
        end
      endcase
    end
  end

  aes_blk_outreg #(.W(BLK_S + 2)) u_outreg (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  ({r_state == S_KEY, s_axis_tlast, r_asm, w_word}),
    .i_ready (blk_ready),
    .o_valid (w_blk_valid),
    .o_data  (w_out)
  );

  assign s_axis_tready = w_tready;
  assign blk_valid     = w_blk_valid;
  assign blk_is_key    = w_out[BLK_S+1];
  assign blk_last      = w_out[BLK_S];
  assign blk_data      = w_out[BLK_S-1:0];
  assign blk_cmd       = r_cmd;
  assign err_frame     = r_err;

endmodule

// File: tb/tb_aes_axis_blk_packer.sv
// Directed bench for the AES stream block packer: expected blocks are queued as
// packets are sent and a negedge monitor pops and compares each delivered block.
module tb_aes_axis_blk_packer;

  typedef struct {
    logic [127:0] d;
    logic [31:0]  c;
    logic         k;
    logic         l;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [0:127]  blk_data;
  logic [31:0]   blk_cmd;
  logic          blk_is_key;
  logic          blk_last;
  logic          blk_valid;
  logic          blk_ready;
  logic          err_frame;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            err_seen = 0;
  int            err_exp = 0;
  bit            bp_mode = 0;
  bit            rdy_force = 1;
  bit            chk_lat = 0;
  bit            pv = 0;
  bit            phs = 0;
  exp_t          expq[$];
  int            t_start[$];
  logic [31:0]   pw[$];

  aes_axis_blk_packer dut (
    .clock         (clock),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .blk_data      (blk_data),
    .blk_cmd       (blk_cmd),
    .blk_is_key    (blk_is_key),
    .blk_last      (blk_last),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .err_frame     (err_frame)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // 2-low / 6-high ready pattern under backpressure, otherwise a static level.
  always @(posedge clock) begin
    #1;
    blk_ready = bp_mode ? ((cyc % 8) >= 2) : rdy_force;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [127:0] d, input logic [31:0] c,
                                   input logic k, input logic l);
    exp_t e;
    e.d = d; e.c = c; e.k = k; e.l = l;
    expq.push_back(e);
  endfunction

  always @(negedge clock) begin
    exp_t e;
    bit   new_blk;
    if (reset) begin
      pv  = 0;
      phs = 0;
    end else begin
      if (err_frame) err_seen++;
      new_blk = blk_valid && (!pv || phs);
      if (chk_lat && new_blk) begin
        if (t_start.size() == 0) chk("latency_start_missing", 1, 0);
        else chk("blk_valid_latency", cyc - t_start.pop_front(), 5);
      end
      if (blk_valid && blk_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_block", {blk_data}, 0);
        end else begin
          e = expq.pop_front();
          chk("blk_data", {blk_data}, e.d);
          chk("blk_cmd", blk_cmd, e.c);
          chk("blk_is_key", blk_is_key, e.k);
          chk("blk_last", blk_last, e.l);
        end
      end
      pv  = blk_valid;
      phs = blk_valid && blk_ready;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit l, input bit stall_ok, input bit is_cmd);
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      chk("tready", s_axis_tready, !(stall_ok && blk_valid && !blk_ready));
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        chk("tready_timeout", 0, 1);
        break;
      end
    end
    if (is_cmd && chk_lat) t_start.push_back(cyc);
    @(posedge clock);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] cmd, input int gapmax);
    send_word(cmd, pw.size() == 0, 1, 1);
    for (int k = 0; k < pw.size(); k++) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      send_word(pw[k], k == pw.size() - 1, (k % 4) == 3, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_pending", expq.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_blk_valid"}, blk_valid, 0);
    chk({tag, "_blk_data"}, {blk_data}, 0);
    chk({tag, "_blk_cmd"}, blk_cmd, 0);
    chk({tag, "_blk_is_key"}, blk_is_key, 0);
    chk({tag, "_blk_last"}, blk_last, 0);
    chk({tag, "_err_frame"}, err_frame, 0);
    chk({tag, "_tready"}, s_axis_tready, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("tready_in_reset", s_axis_tready, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_reset_outputs("por");
    @(posedge clock);
    #1;

    // encrypt, no key
    push_exp(128'h00112233445566778899AABBCCDDEEFF, 32'h1, 0, 1);
    pw = {32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
    send_pkt(32'h01000000, 0);

    // key plus two data blocks
    push_exp(128'h000102030405060708090A0B0C0D0E0F, 32'h3, 1, 0);
    push_exp(128'h101112131415161718191A1B1C1D1E1F, 32'h3, 0, 0);
    push_exp(128'h202122232425262728292A2B2C2D2E2F, 32'h3, 0, 1);
    pw = {32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
          32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C,
          32'h23222120, 32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C};
    send_pkt(32'h03000000, 0);
    drain();

    // backpressure with random source gaps
    bp_mode = 1;
    push_exp(128'h404142434445464748494A4B4C4D4E4F, 32'h1, 0, 0);
    push_exp(128'h505152535455565758595A5B5C5D5E5F, 32'h1, 0, 0);
    push_exp(128'h606162636465666768696A6B6C6D6E6F, 32'h1, 0, 1);
    pw = {32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C,
          32'h53525150, 32'h57565554, 32'h5B5A5958, 32'h5F5E5D5C,
          32'h63626160, 32'h67666564, 32'h6B6A6968, 32'h6F6E6D6C};
    send_pkt(32'h01000000, 2);
    push_exp(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 32'h3, 1, 0);
    push_exp(128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF, 32'h3, 0, 1);
    pw = {32'hC3C2C1C0, 32'hC7C6C5C4, 32'hCBCAC9C8, 32'hCFCECDCC,
          32'hD3D2D1D0, 32'hD7D6D5D4, 32'hDBDAD9D8, 32'hDFDEDDDC};
    send_pkt(32'h03000000, 1);
    drain();
    bp_mode = 0;
    idle(2);

    // framing error: six data words, last on the sixth
    push_exp(128'h707172737475767778797A7B7C7D7E7F, 32'h1, 0, 0);
    err_exp++;
    pw = {32'h73727170, 32'h77767574, 32'h7B7A7978, 32'h7F7E7D7C,
          32'h83828180, 32'h87868584};
    send_pkt(32'h01000000, 0);
    push_exp(128'h909192939495969798999A9B9C9D9E9F, 32'h0, 0, 1);
    pw = {32'h93929190, 32'h97969594, 32'h9B9A9998, 32'h9F9E9D9C};
    send_pkt(32'h00000000, 0);
    drain();

    // back-to-back single-block packets
    chk_lat = 1;
    push_exp(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 32'h1, 0, 1);
    pw = {32'hA3A2A1A0, 32'hA7A6A5A4, 32'hABAAA9A8, 32'hAFAEADAC};
    send_pkt(32'h01000000, 0);
    push_exp(128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 32'h0, 0, 1);
    pw = {32'hB3B2B1B0, 32'hB7B6B5B4, 32'hBBBAB9B8, 32'hBFBEBDBC};
    send_pkt(32'h00000000, 0);
    drain();
    idle(2);
    chk_lat = 0;
    chk("latency_pending", t_start.size(), 0);

    // reset with a pending block and a partial block in flight
    rdy_force = 0;
    idle(2);
    send_word(32'h01000000, 0, 1, 1);
    send_word(32'hE3E2E1E0, 0, 0, 0);
    send_word(32'hE7E6E5E4, 0, 0, 0);
    send_word(32'hEBEAE9E8, 0, 0, 0);
    send_word(32'hEFEEEDEC, 0, 1, 0);
    send_word(32'hE3E2E1E0, 0, 0, 0);
    send_word(32'hE7E6E5E4, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("tready_mid_reset", s_axis_tready, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_reset_outputs("mid");
    rdy_force = 1;
    idle(2);
    push_exp(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 32'h1, 0, 1);
    pw = {32'hF3F2F1F0, 32'hF7F6F5F4, 32'hFBFAF9F8, 32'hFFFEFDFC};
    send_pkt(32'h01000000, 0);
    drain();
    idle(4);

    chk("err_frame_pulses", err_seen, err_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
